ledrx: RTL and testbench
========================

LEDRX -- requirements
Module: ledrx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning clk cycles without a sck rising edge before a partial frame is discarded.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-003 SHALL have port ledrx_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port sck, input, 1 bit: SPI clock from an LED string driver, asynchronous to clk.
REQ-005 SHALL have port mosi, input, 1 bit: SPI data, MSB first, stable around the sck rising edge.
REQ-006 SHALL have outputs red, blue and green, each 8 bits: colour bytes of the last good LED frame.
REQ-007 SHALL have output brightness, 5 bits: header bits [4:0] of the last good LED frame.
REQ-008 SHALL have output ledvalid, 1 bit: one-cycle pulse when a good LED frame is decoded.
REQ-009 SHALL have output stringend, 1 bit: one-cycle pulse when an all-zero end frame is decoded.
REQ-010 SHALL have output frameerr, 1 bit: one-cycle pulse on a malformed or timed-out frame.
REQ-011 SHALL have output ledcount, 8 bits: good LED frames received since the last end frame.
REQ-012 SHALL have output stringlen, 8 bits: ledcount value captured at the last end frame.
REQ-013 SHALL have output busy, 1 bit: high while a frame is partially received.

Function
REQ-014 SHALL pass sck and mosi through equal-depth 2-flop synchronizers, then detect the sck rise as the synchronized sck high while its delayed copy is low.
REQ-015 SHALL, on each detected rise, shift the synchronized mosi into an 8-bit shift register MSB first and increment a 3-bit bit counter.
REQ-016 SHALL run FSM IDLE -> RX_INIT -> RX_RED -> RX_BLUE -> RX_GREEN -> IDLE, advancing on each completed byte (the rise with bit counter 7); IDLE leaves to RX_INIT on the first rise.
REQ-017 SHALL use byte order header, red, blue, green, and hold all four bytes in internal registers until the frame closes.
REQ-018 SHALL classify a frame on the clk edge where the green byte completes; the resulting outputs and pulses SHALL appear on the next edge (1-cycle latency).
REQ-019 SHALL treat a frame as a good LED frame when header[7:5] is 3'b111; for a good LED frame it SHALL update red, blue, green and brightness, pulse ledvalid, and increment ledcount, saturating at 255.
REQ-020 SHALL treat a frame as an end frame when all 32 bits are 0; for an end frame it SHALL pulse stringend, load stringlen from ledcount, and clear ledcount in the same cycle.
REQ-021 SHALL treat every other frame as malformed, including a zero header with non-zero colour and a header with [7:5] not 111; a malformed frame SHALL pulse frameerr and leave all data outputs and counters unchanged.
REQ-022 SHALL count clk cycles since the last rise while busy; on reaching TIMEOUT it SHALL discard the partial frame, pulse frameerr, clear the bit counter and return to IDLE.
REQ-023 SHALL give a rise the priority if it coincides with the timeout cycle; the rise restarts the idle counter and no timeout occurs.
REQ-024 SHALL drive busy as (state != IDLE) or (bit counter != 0).
REQ-025 SHALL never pulse ledvalid, stringend and frameerr in the same cycle.

Reset
REQ-026 SHALL, while ledrx_rst is high, asynchronously clear all outputs, synchronizers, counters, shift and byte registers, and force the FSM to IDLE.
REQ-027 SHALL discard a frame in progress when reset is asserted mid-frame, with no pulse emitted on or after reset release.

Structure
REQ-028 SHALL take the FSM state encodings, the LED header marker 8'hE0 and header mask 3'b111 from a shared package also used by the LED transmit side.
REQ-029 SHALL instantiate one sub-module, spi_rx_sync, that contains both synchronizers and the sck rise detector.

Verification
REQ-030 SHALL cover: frame E0,12,34,56 -> ledvalid for 1 cycle, red=12, blue=34, green=56, brightness=0, ledcount=1.
REQ-031 SHALL cover: header FF then AA,BB,CC -> brightness=31, red=AA, blue=BB, green=CC.
REQ-032 SHALL cover: 3 good frames then 00,00,00,00 -> stringend for 1 cycle, stringlen=3, ledcount=0.
REQ-033 SHALL cover: header 40 then 11,22,33 -> frameerr for 1 cycle, no ledvalid, outputs keep their previous values.
REQ-034 SHALL cover: 12 bits then 64 idle clk -> frameerr for 1 cycle, busy=0; the next frame E0,01,02,03 decodes correctly.
REQ-035 SHALL cover: reset asserted after 20 bits -> all outputs 0, no pulses; the next frame E0,05,06,07 decodes correctly.

Source files
------------

// File: rtl/ledrx_pkg.sv
// LED string receive: shared types and constants.
// Also used by the LED transmit side for state and header encodings.
package ledrx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_INIT,
        ST_RX_RED,
        ST_RX_BLUE,
        ST_RX_GREEN
    } ledrx_state_e;

    typedef enum logic [1:0] {
        FK_NONE,
        FK_GOOD,
        FK_END,
        FK_ERR
    } frame_kind_e;

    localparam logic [7:0] LED_HDR_MARK = 8'hE0;
    localparam logic [2:0] LED_HDR_MASK = 3'b111;

    // Sort a complete 32-bit frame into LED, end or malformed.
    function automatic frame_kind_e classify(
        input logic [7:0] hdr,
        input logic [7:0] r,
        input logic [7:0] b,
        input logic [7:0] g
    );
        if ((hdr[7:5] & LED_HDR_MASK) == LED_HDR_MARK[7:5])
            return FK_GOOD;
        else if ({hdr, r, b, g} == 32'd0)
            return FK_END;
        else
            return FK_ERR;
    endfunction

endpackage

// File: rtl/ledrx_if.sv
// LED receive bundle: SPI inputs plus decoded frame outputs.
// The driver side uses master, the receiver side uses slave.
interface ledrx_if;
    import ledrx_pkg::*;

    logic       sck;
    logic       mosi;
    logic [7:0] red;
    logic [7:0] blue;
    logic [7:0] green;
    logic [4:0] brightness;
    logic       ledvalid;
    logic       stringend;
    logic       frameerr;
    logic [7:0] ledcount;
    logic [7:0] stringlen;
    logic       busy;

    modport master (
        output sck, mosi,
        input  red, blue, green, brightness,
        input  ledvalid, stringend, frameerr,
        input  ledcount, stringlen, busy
    );

    modport slave (
        input  sck, mosi,
        output red, blue, green, brightness,
        output ledvalid, stringend, frameerr,
        output ledcount, stringlen, busy
    );

endinterface

// File: rtl/ledrx_spi_rx_sync.sv
// SPI input synchronizers and sck rising-edge detector.
// sck and mosi see the same two-flop depth so data stays aligned.
module spi_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic mosi,
    output logic sck_rise,
    output logic mosi_s
);

    logic [1:0] sck_sync_q, sck_sync_d;
    logic       sck_dly_q, sck_dly_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;

    // Next-state for the synchronizer chains and delayed sck copy.
    always_comb begin
        sck_sync_d  = {sck_sync_q[0], sck};
        sck_dly_d   = sck_sync_q[1];
        mosi_sync_d = {mosi_sync_q[0], mosi};
    end

    // Synchronizer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            sck_dly_q   <= 1'b0;
            mosi_sync_q <= '0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            sck_dly_q   <= sck_dly_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign sck_rise = sck_sync_q[1] & ~sck_dly_q;
    assign mosi_s   = mosi_sync_q[1];

endmodule

// File: rtl/ledrx.sv
// LED string SPI receiver: assembles 4-byte frames and decodes
// LED, end-of-string and malformed frames with an idle timeout.
module ledrx
    import ledrx_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       ledrx_rst,
    input  logic       sck,
    input  logic       mosi,
    output logic [7:0] red,
    output logic [7:0] blue,
    output logic [7:0] green,
    output logic [4:0] brightness,
    output logic       ledvalid,
    output logic       stringend,
    output logic       frameerr,
    output logic [7:0] ledcount,
    output logic [7:0] stringlen,
    output logic       busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);

    logic sck_rise;
    logic mosi_s;

    spi_rx_sync u_sync (
        .clk      (clk),
        .rst      (ledrx_rst),
        .sck      (sck),
        .mosi     (mosi),
        .sck_rise (sck_rise),
        .mosi_s   (mosi_s)
    );

    ledrx_state_e  state_q, state_d;
    frame_kind_e   kind_q, kind_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [CW-1:0] idle_q, idle_d;
    logic [7:0]    hdr_q, hdr_d;
    logic [7:0]    red_b_q, red_b_d;
    logic [7:0]    blue_b_q, blue_b_d;
    logic [7:0]    grn_b_q, grn_b_d;
    logic [7:0]    red_q, red_d;
    logic [7:0]    blue_q, blue_d;
    logic [7:0]    green_q, green_d;
    logic [4:0]    bright_q, bright_d;
    logic          ledvalid_q, ledvalid_d;
    logic          stringend_q, stringend_d;
    logic          frameerr_q, frameerr_d;
    logic [7:0]    ledcount_q, ledcount_d;
    logic [7:0]    stringlen_q, stringlen_d;
    logic [7:0]    byte_now;
    logic          busy_w;

    assign byte_now = {shreg_q[6:0], mosi_s};
    assign busy_w   = (state_q != ST_IDLE) || (bitcnt_q != 3'd0);

    // Frame assembly, timeout, and the output stage one cycle
    // behind classification.
    always_comb begin
        state_d     = state_q;
        kind_d      = FK_NONE;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        idle_d      = idle_q;
        hdr_d       = hdr_q;
        red_b_d     = red_b_q;
        blue_b_d    = blue_b_q;
        grn_b_d     = grn_b_q;
        red_d       = red_q;
        blue_d      = blue_q;
        green_d     = green_q;
        bright_d    = bright_q;
        ledvalid_d  = 1'b0;
        stringend_d = 1'b0;
        frameerr_d  = 1'b0;
        ledcount_d  = ledcount_q;
        stringlen_d = stringlen_q;

        unique case (kind_q)
            FK_GOOD: begin
                red_d      = red_b_q;
                blue_d     = blue_b_q;
                green_d    = grn_b_q;
                bright_d   = hdr_q[4:0];
                ledvalid_d = 1'b1;
                if (ledcount_q != 8'hFF)
                    ledcount_d = ledcount_q + 8'd1;
            end
            FK_END: begin
                stringend_d = 1'b1;
                stringlen_d = ledcount_q;
                ledcount_d  = 8'd0;
            end
            FK_ERR:  frameerr_d = 1'b1;
            default: ;
        endcase

        if (sck_rise) begin
            shreg_d  = byte_now;
            bitcnt_d = bitcnt_q + 3'd1;
            idle_d   = '0;
            if (state_q == ST_IDLE)
                state_d = ST_RX_INIT;
            if (bitcnt_q == 3'd7) begin
                unique case (state_q)
                    ST_RX_INIT: begin
                        hdr_d   = byte_now;
                        state_d = ST_RX_RED;
                    end
                    ST_RX_RED: begin
                        red_b_d = byte_now;
                        state_d = ST_RX_BLUE;
                    end
                    ST_RX_BLUE: begin
                        blue_b_d = byte_now;
                        state_d  = ST_RX_GREEN;
                    end
                    ST_RX_GREEN: begin
                        grn_b_d = byte_now;
                        kind_d  = classify(hdr_q, red_b_q,
                                           blue_b_q, byte_now);
                        state_d = ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end else if (busy_w) begin
            if (idle_q == IDLE_LAST) begin
                kind_d   = FK_ERR;
                state_d  = ST_IDLE;
                bitcnt_d = 3'd0;
                idle_d   = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    // All state, including registered outputs.
    always_ff @(posedge clk or posedge ledrx_rst) begin
        if (ledrx_rst) begin
            state_q     <= ST_IDLE;
            kind_q      <= FK_NONE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            idle_q      <= '0;
            hdr_q       <= '0;
            red_b_q     <= '0;
            blue_b_q    <= '0;
            grn_b_q     <= '0;
            red_q       <= '0;
            blue_q      <= '0;
            green_q     <= '0;
            bright_q    <= '0;
            ledvalid_q  <= 1'b0;
            stringend_q <= 1'b0;
            frameerr_q  <= 1'b0;
            ledcount_q  <= '0;
            stringlen_q <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            idle_q      <= idle_d;
            hdr_q       <= hdr_d;
            red_b_q     <= red_b_d;
            blue_b_q    <= blue_b_d;
            grn_b_q     <= grn_b_d;
            red_q       <= red_d;
            blue_q      <= blue_d;
            green_q     <= green_d;
            bright_q    <= bright_d;
            ledvalid_q  <= ledvalid_d;
            stringend_q <= stringend_d;
            frameerr_q  <= frameerr_d;
            ledcount_q  <= ledcount_d;
            stringlen_q <= stringlen_d;
        end
    end

    assign red        = red_q;
    assign blue       = blue_q;
    assign green      = green_q;
    assign brightness = bright_q;
    assign ledvalid   = ledvalid_q;
    assign stringend  = stringend_q;
    assign frameerr   = frameerr_q;
    assign ledcount   = ledcount_q;
    assign stringlen  = stringlen_q;
    assign busy       = busy_w;

endmodule

// File: tb/tb_ledrx.sv
// Scoreboard bench for ledrx: directed frames, random frames,
// timeouts, mid-frame reset and ledcount saturation.
module tb_ledrx;

    localparam int TO = 64;

    typedef struct {
        int         kind;
        logic [7:0] r;
        logic [7:0] b;
        logic [7:0] g;
        logic [4:0] br;
        logic [7:0] lc;
        logic [7:0] sl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ledrx_if u_if ();

    ledrx #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .ledrx_rst  (rst),
        .sck        (u_if.sck),
        .mosi       (u_if.mosi),
        .red        (u_if.red),
        .blue       (u_if.blue),
        .green      (u_if.green),
        .brightness (u_if.brightness),
        .ledvalid   (u_if.ledvalid),
        .stringend  (u_if.stringend),
        .frameerr   (u_if.frameerr),
        .ledcount   (u_if.ledcount),
        .stringlen  (u_if.stringlen),
        .busy       (u_if.busy)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    exp_t sb[$];

    // Reference state: the last good frame and the counters.
    logic [7:0] m_r, m_b, m_g, m_lc, m_sl;
    logic [4:0] m_br;
    int hp = 3;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_r = 0; m_b = 0; m_g = 0; m_br = 0; m_lc = 0; m_sl = 0;
    endtask

    task automatic model_frame(input logic [7:0] h, input logic [7:0] r,
                               input logic [7:0] b, input logic [7:0] g);
        exp_t e;
        if (h[7:5] == 3'b111) begin
            e.kind = 1;
            m_r = r; m_b = b; m_g = g; m_br = h[4:0];
            if (m_lc < 255) m_lc = m_lc + 1;
        end else if (h == 0 && r == 0 && b == 0 && g == 0) begin
            e.kind = 2;
            m_sl = m_lc;
            m_lc = 0;
        end else begin
            e.kind = 3;
        end
        e.r = m_r; e.b = m_b; e.g = m_g; e.br = m_br;
        e.lc = m_lc; e.sl = m_sl;
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.kind = 3;
        e.r = m_r; e.b = m_b; e.g = m_g; e.br = m_br;
        e.lc = m_lc; e.sl = m_sl;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic v);
        u_if.mosi = v;
        repeat (hp) @(posedge clk);
        u_if.sck = 1'b1;
        repeat (hp) @(posedge clk);
        u_if.sck = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] r,
                              input logic [7:0] b, input logic [7:0] g);
        logic [31:0] w;
        model_frame(h, r, b, g);
        w = {h, r, b, g};
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
        repeat (4) @(posedge clk);
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
        push_err();
        repeat (TO + 10) @(posedge clk);
        @(negedge clk);
        chk("busy_after_timeout", int'(u_if.busy), 0);
    endtask

    // Monitor: pop the scoreboard on every DUT pulse.
    always @(negedge clk) begin
        int n;
        int k;
        exp_t e;
        n = int'(u_if.ledvalid) + int'(u_if.stringend) + int'(u_if.frameerr);
        if (n > 1) chk("pulse_exclusive", n, 1);
        if (n > 0) begin
            k = u_if.ledvalid ? 1 : (u_if.stringend ? 2 : 3);
            if (sb.size() == 0) begin
                chk("unexpected_pulse_kind", k, 0);
            end else begin
                e = sb.pop_front();
                chk("kind", k, e.kind);
                chk("red", int'(u_if.red), int'(e.r));
                chk("blue", int'(u_if.blue), int'(e.b));
                chk("green", int'(u_if.green), int'(e.g));
                chk("brightness", int'(u_if.brightness), int'(e.br));
                chk("ledcount", int'(u_if.ledcount), int'(e.lc));
                chk("stringlen", int'(u_if.stringlen), int'(e.sl));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_red"}, int'(u_if.red), 0);
        chk({tag, "_blue"}, int'(u_if.blue), 0);
        chk({tag, "_green"}, int'(u_if.green), 0);
        chk({tag, "_bright"}, int'(u_if.brightness), 0);
        chk({tag, "_lc"}, int'(u_if.ledcount), 0);
        chk({tag, "_sl"}, int'(u_if.stringlen), 0);
        chk({tag, "_busy"}, int'(u_if.busy), 0);
        chk({tag, "_pulses"},
            int'({u_if.ledvalid, u_if.stringend, u_if.frameerr}), 0);
    endtask

    initial begin
        logic [7:0] h, r, b, g;
        int typ;
        int budget;
        u_if.sck = 1'b0;
        u_if.mosi = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        send_frame(8'hE0, 8'h12, 8'h34, 8'h56);
        send_frame(8'hFF, 8'hAA, 8'hBB, 8'hCC);
        send_frame(8'hE7, 8'h01, 8'h01, 8'h01);
        send_frame(8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(8'h40, 8'h11, 8'h22, 8'h33);
        send_frame(8'h00, 8'h00, 8'h5A, 8'h00);
        send_partial(12);
        send_frame(8'hE0, 8'h01, 8'h02, 8'h03);

        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk_all_zero("midreset");
        @(posedge clk);
        rst = 1'b0;
        repeat (TO + 10) @(posedge clk);
        send_frame(8'hE0, 8'h05, 8'h06, 8'h07);

        for (int i = 0; i < 40; i++) begin
            typ = $urandom_range(0, 4);
            r = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            g = 8'($urandom_range(0, 255));
            case (typ)
                0, 1: send_frame({3'b111, 5'($urandom_range(0, 31))},
                                 r, b, g);
                2: send_frame(8'h00, 8'h00, 8'h00, 8'h00);
                3: begin
                    h = 8'($urandom_range(0, 255));
                    if (h[7:5] == 3'b111) h[7] = 1'b0;
                    if (h == 0) r[0] = 1'b1;
                    send_frame(h, r, b, g);
                end
                default: send_partial($urandom_range(1, 31));
            endcase
        end

        hp = 2;
        send_frame(8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 260; i++)
            send_frame(8'hE1, 8'(i), 8'h00, 8'hFF);
        send_frame(8'h00, 8'h00, 8'h00, 8'h00);

        budget = 0;
        while (sb.size() != 0 && budget < 500) begin
            @(posedge clk);
            budget++;
        end
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
